// File: rtl/fp_pkg.sv
// Shared single-precision FP types for the add/sub datapath and its writeback stage.
package fp;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

endpackage

// File: rtl/fp_add_wb_classify.sv
// Combinational classifier: derives RISC-V exception flags from an adder result.
// FP_WB_CANON_NAN_EN replaces invalid/NaN results with the canonical quiet NaN.
module fp_flag_classify
    import fp::*;
(
    input  logic [31:0] in_result,
    input  logic        in_error,
    input  logic        in_inexact,
    input  logic        in_src_inf,
    output fp_t         out_result,
    output fflags_t     out_flags
);

    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_is_inf;
    logic        w_overflow;

    assign w_exp  = in_result[30:23];
    assign w_frac = in_result[22:0];

    assign w_is_inf = (w_exp == 8'hFF) && (w_frac == '0);
    // An Inf produced from finite operands is an overflow; an Inf operand just propagates.
    assign w_overflow = w_is_inf && !in_src_inf && !in_error;

    assign out_flags.nv = in_error;
    assign out_flags.dz = 1'b0;
    assign out_flags.of = w_overflow;
    assign out_flags.uf = (w_exp == 8'h00) && (w_frac != '0) && in_inexact;
    assign out_flags.nx = in_inexact || w_overflow;

`ifdef FP_WB_CANON_NAN_EN
    logic w_is_nan;
    assign w_is_nan   = (w_exp == 8'hFF) && (w_frac != '0);
    assign out_result = (in_error || w_is_nan) ? fp_t'(CANON_NAN) : fp_t'(in_result);
`else
    assign out_result = fp_t'(in_result);
`endif

endmodule

// File: rtl/fp_add_wb.sv
// FP add/sub writeback stage: result FIFO with valid/ready handshake and sticky fflags.
// Optional build macro FP_WB_CANON_NAN_EN (handled in fp_flag_classify).
module fp_add_wb
    import fp::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RD_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_result,
    input  logic            in_error,
    input  logic            in_inexact,
    input  logic            in_src_inf,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic [4:0]      out_flags,
    input  logic            fflags_clr,
    output logic [4:0]      fflags
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fp_t             r_mem_result [DEPTH];
    logic [RD_W-1:0] r_mem_rd     [DEPTH];
    fflags_t         r_mem_flags  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_fflags;

    fp_t     w_cls_result;
    fflags_t w_cls_flags;
    logic    w_push;
    logic    w_pop;

    fp_flag_classify u_classify (
        .in_result  (in_result),
        .in_error   (in_error),
        .in_inexact (in_inexact),
        .in_src_inf (in_src_inf),
        .out_result (w_cls_result),
        .out_flags  (w_cls_flags)
    );

    assign in_ready  = !reset && (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_result = r_mem_result[r_rd_ptr];
    assign out_rd     = r_mem_rd[r_rd_ptr];
    assign out_flags  = r_mem_flags[r_rd_ptr];
    assign fflags     = r_fflags;

    // Storage is deliberately not reset; in_ready already blocks pushes during reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= w_cls_result;
            r_mem_rd[r_wr_ptr]     <= in_rd;
            r_mem_flags[r_wr_ptr]  <= w_cls_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fflags <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Flags committed in the same cycle as a clear survive it.
            r_fflags <= (fflags_clr ? 5'b0 : r_fflags) | (w_pop ? out_flags : 5'b0);
        end
    end

endmodule

// File: tb/tb_fp_add_wb.sv
// Self-checking bench for fp_add_wb: directed scenarios plus random traffic vs a queue model.
module tb_fp_add_wb;

    localparam int DEPTH = 2;
    localparam int RD_W  = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_result = '0;
    logic            in_error = 1'b0;
    logic            in_inexact = 1'b0;
    logic            in_src_inf = 1'b0;
    logic [RD_W-1:0] in_rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_result;
    logic [RD_W-1:0] out_rd;
    logic [4:0]      out_flags;
    logic            fflags_clr = 1'b0;
    logic [4:0]      fflags;

    typedef struct {
        logic [31:0]     res;
        logic [RD_W-1:0] rd;
        logic [4:0]      fl;
    } ent_t;

    ent_t       q[$];
    logic [4:0] sticky = '0;
    int         n_vec = 0;
    int         n_err = 0;

    fp_add_wb #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_error   (in_error),
        .in_inexact (in_inexact),
        .in_src_inf (in_src_inf),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_flags  (out_flags),
        .fflags_clr (fflags_clr),
        .fflags     (fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_flags(input logic [31:0] r, input logic e,
                                             input logic i, input logic s);
        logic [7:0]  ex = r[30:23];
        logic [22:0] fr = r[22:0];
        logic        of = (ex == 8'hFF) && (fr == 23'd0) && !s && !e;
        logic        uf = (ex == 8'h00) && (fr != 23'd0) && i;
        return {e, 1'b0, of, uf, i || of};
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] r, input logic e);
`ifdef FP_WB_CANON_NAN_EN
        logic [31:0] canon = 32'h7FC00000;
        if (e || (r[30:23] == 8'hFF && r[22:0] != 23'd0)) return canon;
`endif
        if (e) return r;
        return r;
    endfunction

    // Check outputs against the model mid-cycle, then advance one clock and update the model.
    task automatic tick();
        bit         push;
        bit         pop;
        logic [4:0] popped;
        ent_t       e;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!reset && q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0 && out_valid) begin
            chk("out_result", out_result, q[0].res);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_flags", 32'(out_flags), 32'(q[0].fl));
        end
        chk("fflags", 32'(fflags), 32'(sticky));
        push   = in_valid && !reset && q.size() < DEPTH;
        pop    = !reset && q.size() > 0 && out_ready;
        popped = pop ? q[0].fl : 5'b0;
        e.res  = ref_result(in_result, in_error);
        e.rd   = in_rd;
        e.fl   = ref_flags(in_result, in_error, in_inexact, in_src_inf);
        @(posedge clk);
        if (reset) begin
            q.delete();
            sticky = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            sticky = (fflags_clr ? 5'b0 : sticky) | popped;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [RD_W-1:0] rd,
                         input logic err, input logic inex, input logic sinf,
                         input logic ordy, input logic clr);
        in_valid   = v;
        in_result  = r;
        in_rd      = rd;
        in_error   = err;
        in_inexact = inex;
        in_src_inf = sinf;
        out_ready  = ordy;
        fflags_clr = clr;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: r[30:0] = {8'hFF, 23'd0};
            1: r[30:23] = 8'hFF;
            2: r[30:23] = 8'h00;
            3: r[30:0] = '0;
            4: r = 32'h3F800000;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] exp_nv;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single push with immediate drain.
        drive(1, 32'h3F800000, 3, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'h3F800000);
        chk("t1_rd", 32'(out_rd), 32'd3);
        tick();
        chk("t1_empty", 32'(out_valid), 32'd0);

        // Fill, hold third push, drain across pointer wrap.
        drive(1, 32'd1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'd2, 2, 0, 0, 0, 0, 0);
        tick();
        chk("t2_full", 32'(in_ready), 32'd0);
        drive(1, 32'd3, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'd3, 3, 0, 0, 0, 1, 0);
        tick();
        chk("t2_second", out_result, 32'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t2_third", out_result, 32'd3);
        tick();
        tick();

        // Overflow versus propagated infinity.
        drive(1, 32'h7F800000, 4, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_of_flags", 32'(out_flags), 32'h05);
        out_ready = 1'b1;
        tick();
        chk("t3_sticky", 32'(fflags), 32'h05);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h7F800000, 5, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t3_inf_flags", 32'(out_flags), 32'h00);
        tick();

        // Invalid operation.
        drive(1, 32'h12345678, 6, 1, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t4_nv_flags", 32'(out_flags), 32'h10);
`ifdef FP_WB_CANON_NAN_EN
        exp_nv = 32'h7FC00000;
`else
        exp_nv = 32'h12345678;
`endif
        chk("t4_nv_result", out_result, exp_nv);
        tick();
        chk("t4_sticky", 32'(fflags), 32'h10);

        // Clear coinciding with a pop keeps the popped flags.
        drive(1, 32'h3F800000, 7, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        chk("t5_clr_pop", 32'(fflags), 32'h01);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("t5_clr", 32'(fflags), 32'h00);

        // Reset with entries buffered discards them.
        drive(1, 32'h7F800000, 8, 0, 1, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_fflags", 32'(fflags), 32'd0);
        tick();
        tick();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), rand_fp(), RD_W'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
